// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised register file with NRD combinational read ports,
// one write port and a sequential clear engine. The clear engine walks every
// entry after reset or on a clr request.
// Optional feature macro: REG_FILE_BYPASS_EN. When it is defined, a legal
// same-cycle write is forwarded to any read port addressing the same entry.
module reg_file_mp #(
   parameter  int XLEN     = 32,
   parameter  int NREG     = 32,
   parameter  int NRD      = 2,
   parameter  int ZERO_REG = 1,
   localparam int AW       = $clog2(NREG)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   output logic                 ready,
   input  logic                 WE3,
   input  logic [AW-1:0]        A3,
   input  logic [XLEN-1:0]      WD3,
   input  logic [NRD*AW-1:0]    raddr,
   output logic [NRD*XLEN-1:0]  rdata,
   output logic                 wr_drop
);

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   localparam logic [AW:0]   NREG_C   = (AW+1)'(NREG);
   localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

   state_t            state_q, state_d;
   logic [AW-1:0]     idx_q, idx_d;
   logic              ready_q, ready_d;
   logic              wr_drop_q, wr_drop_d;
   logic              clear_we_s;
   logic              write_s;
   logic [XLEN-1:0]   mem_q [NREG];

   // An address names a real, writable/readable entry (in range, not a hardwired zero).
   function automatic logic addr_ok(input logic [AW-1:0] a);
      logic zero_hit;
      zero_hit = (ZERO_REG == 1) && (a == AW'(0));
      return ({1'b0, a} < NREG_C) && !zero_hit;
   endfunction

   // Control state register: FSM state, clear index, registered ready and drop flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_CLEAR;
         idx_q     <= '0;
         ready_q   <= 1'b0;
         wr_drop_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         ready_q   <= ready_d;
         wr_drop_q <= wr_drop_d;
      end
   end

   // Next-state logic: walk the clear index to the last entry, then run until clr.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         ST_CLEAR: begin
            if (idx_q == LAST_IDX) begin
               state_d = ST_RUN;
               idx_d   = '0;
            end else begin
               state_d = ST_CLEAR;
               idx_d   = idx_q + AW'(1);
            end
         end
         ST_RUN: begin
            if (clr) begin
               state_d = ST_CLEAR;
               idx_d   = '0;
            end else begin
               state_d = ST_RUN;
               idx_d   = idx_q;
            end
         end
         default: begin
            state_d = ST_CLEAR;
            idx_d   = '0;
         end
      endcase
   end

   // Output/strobe logic: clear and write strobes, next ready and write-drop flag.
   always_comb begin
      ready_d    = (state_d == ST_RUN);
      clear_we_s = (state_q == ST_CLEAR);
      write_s    = ready_q && WE3 && !clr && addr_ok(A3);
      wr_drop_d  = WE3 && (!ready_q || clr);
   end

   // Storage array: clear engine and write port never overlap (CLEAR vs RUN).
   always_ff @(posedge clk) begin
      if (rst && clear_we_s) begin
         mem_q[idx_q] <= '0;
      end else if (rst && write_s) begin
         mem_q[A3] <= WD3;
      end
   end

   // Combinational read ports; illegal addresses and the clearing phase read as zero.
   always_comb begin : read_ports
      logic [AW-1:0] ra;
      ra    = '0;
      rdata = '0;
      for (int i = 0; i < NRD; i++) begin
         ra = raddr[i*AW +: AW];
         if (ready_q && addr_ok(ra)) begin
`ifdef REG_FILE_BYPASS_EN
            if (write_s && (A3 == ra)) begin
               rdata[i*XLEN +: XLEN] = WD3;
            end else begin
               rdata[i*XLEN +: XLEN] = mem_q[ra];
            end
`else
            rdata[i*XLEN +: XLEN] = mem_q[ra];
`endif
         end else begin
            rdata[i*XLEN +: XLEN] = '0;
         end
      end
   end

   assign ready   = ready_q;
   assign wr_drop = wr_drop_q;

endmodule
